// File: rtl/cook_timer_pkg.sv
// Shared types and constants for the microwave cook timer controller.
// Entry layout is {min_tens, min_ones, sec_tens, sec_ones}, one BCD digit each.
package cook_timer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_LOAD  = 3'd2,
        S_COOK  = 3'd3,
        S_PAUSE = 3'd4,
        S_CLEAR = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned SEC_ONES_LSB = 0;
    localparam int unsigned SEC_TENS_LSB = 4;
    localparam int unsigned MIN_ONES_LSB = 8;
    localparam int unsigned MIN_TENS_LSB = 12;

endpackage

// File: rtl/cook_timer_if.sv
// Bus between the controller and the cascaded BCD countdown chain.
// The controller is the master; the counter chain answers with all_zero.
interface cook_timer_if;

    logic        chain_loadn;
    logic        chain_enable;
    logic [15:0] chain_data;
    logic        all_zero;

    modport master (
        output chain_loadn,
        output chain_enable,
        output chain_data,
        input  all_zero
    );

    modport slave (
        input  chain_loadn,
        input  chain_enable,
        input  chain_data,
        output all_zero
    );

endinterface

// File: rtl/keypad_entry.sv
// Four-digit MM:SS keypad shift register with digit and time validation.
// Clear wins over shift; a fifth digit pushes the oldest one out.
module keypad_entry
    import cook_timer_pkg::*;
(
    input  logic        clock,
    input  logic        clrn,
    input  logic        shift_en,
    input  logic        clr,
    input  logic [3:0]  digit,
    output logic        digit_ok,
    output logic [15:0] entry,
    output logic        entry_valid
);

    logic [15:0] entry_q;
    logic [15:0] entry_d;
    logic [3:0]  sec_tens;

    assign digit_ok = (digit <= BCD_MAX);
    assign sec_tens = entry_q[SEC_TENS_LSB +: DIGIT_W];

    always_comb begin
        entry_d = entry_q;
        if (clr) begin
            entry_d = '0;
        end else if (shift_en && digit_ok) begin
            entry_d = {entry_q[11:0], digit};
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry       = entry_q;
    assign entry_valid = (entry_q != 16'h0000) && (sec_tens <= SEC_TENS_MAX);

endmodule

// File: rtl/cook_timer_ctrl.sv
// Cook timer sequencer: keypad entry, chain load, tick-gated countdown,
// magnetron drive, door/stop/start handling and the end-of-cycle beep.
module cook_timer_ctrl
    import cook_timer_pkg::*;
#(
    parameter int BEEP_TICKS = 3
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic        tick,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        start_n,
    input  logic        stop_n,
    input  logic        door_closed,
    cook_timer_if.master chain,
    output logic        mag_on,
    output logic        beep,
    output logic        entry_err,
    output logic [2:0]  state
);

    localparam logic [3:0] BEEP_LAST = 4'(BEEP_TICKS - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        shift_en;
    logic        entry_clr;
    logic        digit_ok;
    logic        entry_valid;
    logic [15:0] entry;

    keypad_entry u_entry (
        .clock       (clock),
        .clrn        (clrn),
        .shift_en    (shift_en),
        .clr         (entry_clr),
        .digit       (key_digit),
        .digit_ok    (digit_ok),
        .entry       (entry),
        .entry_valid (entry_valid)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        err_d     = 1'b0;
        shift_en  = 1'b0;
        entry_clr = 1'b0;
        unique case (state_q)
            S_IDLE, S_SET: begin
                if (!stop_n) begin
                    state_d   = S_IDLE;
                    entry_clr = 1'b1;
                end else if (!start_n) begin
                    if (state_q == S_SET) begin
                        if (door_closed && entry_valid) begin
                            state_d = S_LOAD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (key_valid && digit_ok) begin
                    shift_en = 1'b1;
                    state_d  = S_SET;
                end
            end
            S_LOAD: begin
                state_d = S_COOK;
            end
            S_COOK: begin
                if (!door_closed || !stop_n) begin
                    state_d = S_PAUSE;
                end else if (chain.all_zero) begin
                    state_d = S_DONE;
                end
            end
            S_PAUSE: begin
                if (!stop_n) begin
                    state_d = S_CLEAR;
                end else if (!start_n && door_closed) begin
                    state_d = S_COOK;
                end
            end
            S_CLEAR: begin
                state_d   = S_IDLE;
                entry_clr = 1'b1;
            end
            S_DONE: begin
                cnt_d = cnt_q;
                // Any user action silences the beep; the key itself is dropped.
                if (key_valid || !start_n || !stop_n) begin
                    state_d   = S_IDLE;
                    entry_clr = 1'b1;
                end else if (tick) begin
                    if (cnt_q == BEEP_LAST) begin
                        state_d   = S_IDLE;
                        entry_clr = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                entry_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign chain.chain_loadn  = !(state_q == S_LOAD || state_q == S_CLEAR);
    assign chain.chain_data   = (state_q == S_CLEAR) ? 16'h0000 : entry;
    assign chain.chain_enable = (state_q == S_COOK) && tick
                              && door_closed && !chain.all_zero;

    assign mag_on    = (state_q == S_COOK);
    assign beep      = (state_q == S_DONE);
    assign entry_err = err_q;
    assign state     = state_q;

endmodule

// File: doc/cook_timer_ctrl.md
# cook_timer_ctrl

Sequencing controller for the microwave MM:SS countdown chain (four cascaded BCD down-counters: min-tens, min-ones, sec-tens mod-6, sec-ones mod-10). It collects keypad digits, loads them into the chain, gates the count enable with the 1 Hz tick, drives the magnetron and handles door/stop/start events. It ends each cycle with a timed beep. It sits between the keypad/door inputs and the counter chain's `loadn`/`enable`/`data` pins.

## Interface
- `BEEP_TICKS`, 3, number of 1 Hz ticks the beep stays on in DONE (1..15)
- `clock`  in  1  system clock
- `clrn`  in  1  reset, asynchronous, active-low
- `tick`  in  1  one-clock pulse per second from the prescaler
- `key_valid`  in  1  one-clock strobe, new keypad digit
- `key_digit`  in  4  keypad digit code; 0–9 valid, 10–15 ignored
- `start_n`, `stop_n`  in  1 each  one-clock active-low button strobes (already debounced)
- `door_closed`  in  1  level, 1 = door closed
- `all_zero`  in  1  AND of the four counter `zero` flags
- `chain_loadn`  out  1  active-low load to all counters
- `chain_enable`  out  1  count enable into sec-ones (chain cascades via `tc`)
- `chain_data`  out  16  {min_tens, min_ones, sec_tens, sec_ones} BCD load value
- `mag_on`  out  1  magnetron drive
- `beep`  out  1  buzzer drive
- `entry_err`  out  1  one-clock pulse on rejected start
- `state`  out  3  current FSM state, for display/debug

## Operation
- States: IDLE, SET, LOAD, COOK, PAUSE, CLEAR, DONE.
- Entry register `entry[15:0]`, reset 0. In IDLE/SET, `key_valid` with digit ≤ 9 shifts `entry <= {entry[11:0], key_digit}` and goes to SET. Other states ignore keys, except DONE (see below).
- SET + `start_n`=0:
  - Door closed, entry ≠ 0 and `entry[7:4]` ≤ 5 → LOAD.
  - Otherwise pulse `entry_err` and stay in SET.
- SET + `stop_n`=0 → clear entry, go to IDLE.
- LOAD: `chain_loadn`=0 and `chain_data`=entry for exactly one clock, then COOK.
- COOK:
  - `mag_on`=1.
  - `chain_enable` = `tick` & `door_closed` & !`all_zero`.
  - `all_zero`=1 → DONE, `mag_on` drops the same edge.
  - Door opens → PAUSE.
  - `stop_n`=0 → PAUSE.
- PAUSE: `mag_on`=0, `chain_enable`=0.
  - `start_n`=0 with door closed → COOK; counters resume from their held value, no reload.
  - `stop_n`=0 → CLEAR.
- CLEAR: `chain_loadn`=0, `chain_data`=0 for one clock, entry cleared, then IDLE.
- DONE:
  - `beep`=1; the beep counter increments on `tick`.
  - After `BEEP_TICKS` ticks → IDLE with entry cleared.
  - Any `key_valid`, `start_n`=0 or `stop_n`=0 in DONE → IDLE immediately; that key is not captured.
- Priority within a cycle: door open > stop > start > key.
- In every state other than LOAD and CLEAR: `chain_loadn`=1 and `chain_data`=entry.

## Timing
- Reset values: state=IDLE, entry=0, beep counter=0, `chain_loadn`=1, `chain_enable`=0, `chain_data`=0, `mag_on`=0, `beep`=0, `entry_err`=0.
- All outputs are decoded from registered state/entry (Moore), except `chain_enable`, which is combinational from `tick`/`door_closed`/`all_zero` in COOK.
- Counters load on the clock edge that ends LOAD. `all_zero` is therefore valid from the first COOK cycle; a nonzero entry guarantees no false DONE.
- Countdown 00:01 → 00:00 happens on a tick edge. `all_zero` is seen the next cycle, so DONE is entered ≤ 2 clocks after that tick.
- Door opening in the same cycle as a tick in COOK: enable is blocked and that second is not counted.
- `clrn` asserted mid-COOK: immediate IDLE, `mag_on`=0 asynchronously. The counter chain is reset by its own `clrn`.
- A fifth digit entered shifts out the oldest digit (wrap).

## Structure
- Package `cook_timer_pkg`:
  - state enum encoding (3 bits);
  - `BCD_MAX`=9, `SEC_TENS_MAX`=5;
  - digit-field slice constants for `entry`.
- Sub-module `keypad_entry`: the 16-bit shift register with digit validation, clear input and the `entry_valid` check (nonzero, sec-tens ≤ 5).
- FSM and beep counter live in the top module.

## Test plan
- Keys 1,3,0 then start with door closed → one-clock `chain_loadn`=0 with `chain_data`=16'h0130, then COOK with `mag_on`=1.
- Keys 7,0 (sec-tens = 7) then start → `entry_err` one-clock pulse, state stays SET, `chain_loadn` stays 1.
- COOK, door opens coincident with a tick → `chain_enable` stays 0, state PAUSE, `mag_on`=0. Close door and press start → COOK with no load pulse.
- Load 00:02, apply 2 ticks → `all_zero` rises, DONE within 2 clocks. `beep`=1 for 3 ticks, then IDLE.
- PAUSE then stop → CLEAR, with one clock of `chain_loadn`=0 and `chain_data`=0, then IDLE with entry=0.
- Assert `clrn` mid-COOK → all outputs at reset values immediately; after release, key 5 goes to SET with entry=16'h0005.
